mul_div_unit: RTL

//  Iterative multiply/divide unit with HI/LO result registers, downstream of register_file.

---
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers.
// Operands are reduced to magnitudes on start; the sign is re-applied in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO writes accepted
  // S_RUN  | one shift-add / restoring-subtract step per cycle
  // S_FIX  | sign correction, HI/LO update, done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_q, sign_d;
  logic             rsign_q, rsign_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] up_q, up_d;
  logic [WIDTH-1:0] lw_q, lw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbzo_q, dbzo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sum, shl, diff;
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic [WIDTH-1:0] quo_fix, rem_src, rem_fix;

  assign a_neg    = ~op[0] & srcA[WIDTH-1];
  assign b_neg    = ~op[0] & srcB[WIDTH-1];
  assign abs_a    = a_neg ? -srcA : srcA;
  assign abs_b    = b_neg ? -srcB : srcB;

  assign add_sum  = {1'b0, up_q} + (lw_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign shl      = {up_q, lw_q[WIDTH-1]};
  assign diff     = shl - {1'b0, m_q};

  assign prod_raw = {up_q, lw_q};
  assign prod     = sign_q ? -prod_raw : prod_raw;
  assign quo_fix  = sign_q ? -lw_q : lw_q;
  // With a zero divisor the datapath is frozen, so lw_q still holds |dividend|.
  assign rem_src  = dbz_q ? lw_q : up_q;
  assign rem_fix  = rsign_q ? -rem_src : rem_src;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    dbz_d    = dbz_q;
    m_d      = m_q;
    up_d     = up_q;
    lw_d     = lw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbzo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wd;
        if (wr_lo) lo_d = wd;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          sign_d   = a_neg ^ b_neg;
          rsign_d  = a_neg;
          dbz_d    = op[1] & (srcB == '0);
          up_d     = '0;
          lw_d     = op[1] ? abs_a : abs_b;
          m_d      = op[1] ? abs_b : abs_a;
        end
      end
      S_RUN: begin
        if (!dbz_q) begin
          if (is_div_q) begin
            if (!diff[WIDTH]) begin
              up_d = diff[WIDTH-1:0];
              lw_d = {lw_q[WIDTH-2:0], 1'b1};
            end else begin
              up_d = shl[WIDTH-1:0];
              lw_d = {lw_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            up_d = add_sum[WIDTH:1];
            lw_d = {add_sum[0], lw_q[WIDTH-1:1]};
          end
        end
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbzo_d  = dbz_q;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dbz_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      dbz_q    <= 1'b0;
      m_q      <= '0;
      up_q     <= '0;
      lw_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbzo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      dbz_q    <= dbz_d;
      m_q      <= m_d;
      up_q     <= up_d;
      lw_q     <= lw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbzo_q   <= dbzo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbzo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule
